// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arbiter_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction read port and a data read/write port onto one
// single-port RAM with a fixed one-cycle response path.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_WAIT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        ram_req,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

    owner_t             r_owner;
    owner_t             w_owner_next;
    logic               r_last_instr;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               w_pick_instr;
    logic               w_i_gnt;
    logic               w_d_gnt;

    // Tie-break only matters when both ports request in the same cycle.
    always_comb begin
        w_pick_instr = 1'b0;
        if (ROUND_ROBIN != 0) begin
            w_pick_instr = !r_last_instr;
        end else begin
            w_pick_instr = (r_wait == L_MAX_WAIT);
        end
        w_i_gnt = rst_n && i_req && (!d_req || w_pick_instr);
        w_d_gnt = rst_n && d_req && !w_i_gnt;
    end

    always_comb begin
        w_wait_next = '0;
        if (ROUND_ROBIN == 0 && i_req && !w_i_gnt) begin
            w_wait_next = (r_wait == L_MAX_WAIT) ? r_wait : r_wait + 1'b1;
        end
        w_owner_next = OWN_NONE;
        if (w_i_gnt) begin
            w_owner_next = OWN_INSTR;
        end else if (w_d_gnt) begin
            w_owner_next = OWN_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_NONE;
            r_last_instr <= 1'b1;
            r_wait       <= '0;
        end else begin
            r_owner <= w_owner_next;
            r_wait  <= w_wait_next;
            if (w_i_gnt || w_d_gnt) begin
                r_last_instr <= w_i_gnt;
            end
        end
    end

    always_comb begin
        ram_req   = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_wdata = '0;
        if (w_i_gnt) begin
            ram_req  = 1'b1;
            ram_addr = i_addr;
            ram_be   = 4'hF;
        end else if (w_d_gnt) begin
            ram_req   = 1'b1;
            ram_addr  = d_addr;
            ram_we    = d_we;
            ram_be    = d_be;
            ram_wdata = d_wdata;
        end
    end

    // Owner of last cycle's access decides who sees this cycle's RAM data.
    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = (r_owner == OWN_INSTR);
    assign d_rvalid = (r_owner == OWN_DATA);
    assign i_rdata  = i_rvalid ? ram_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: dut0 round-robin, dut1 fixed priority, each with its own RAM model.
module tb_ram_arbiter;

    typedef struct packed {
        int          stamp;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic run;
    logic done;
    logic mem_init;
    int   cyc;
    int   vectors;
    int   errors;

    logic        i_req_s   [2];
    logic [31:0] i_addr_s  [2];
    logic        d_req_s   [2];
    logic [31:0] d_addr_s  [2];
    logic        d_we_s    [2];
    logic [3:0]  d_be_s    [2];
    logic [31:0] d_wdata_s [2];

    logic        gnt_o     [4];
    logic        rvalid_o  [4];
    logic [31:0] rdata_o   [4];
    logic        ram_req_o [2];
    logic [31:0] ram_addr_o[2];
    logic        ram_we_o  [2];
    logic [3:0]  ram_be_o  [2];
    logic [31:0] ram_wd_o  [2];

    logic        exp_gnt   [4];
    logic        exp_rreq  [2];
    logic        exp_rwe   [2];
    logic [3:0]  exp_rbe   [2];
    logic [31:0] exp_raddr [2];
    logic [31:0] exp_rwd   [2];
    exp_t        exp_q     [4][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic [31:0] mem [0:63];
            logic [31:0] rd_reg;

            ram_arbiter #(
                .ROUND_ROBIN((gi == 0) ? 1 : 0),
                .MAX_WAIT   (4)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_req    (i_req_s[gi]),
                .i_addr   (i_addr_s[gi]),
                .i_gnt    (gnt_o[2*gi]),
                .i_rvalid (rvalid_o[2*gi]),
                .i_rdata  (rdata_o[2*gi]),
                .d_req    (d_req_s[gi]),
                .d_addr   (d_addr_s[gi]),
                .d_we     (d_we_s[gi]),
                .d_be     (d_be_s[gi]),
                .d_wdata  (d_wdata_s[gi]),
                .d_gnt    (gnt_o[2*gi+1]),
                .d_rvalid (rvalid_o[2*gi+1]),
                .d_rdata  (rdata_o[2*gi+1]),
                .ram_req  (ram_req_o[gi]),
                .ram_addr (ram_addr_o[gi]),
                .ram_we   (ram_we_o[gi]),
                .ram_be   (ram_be_o[gi]),
                .ram_wdata(ram_wd_o[gi]),
                .ram_rdata(rd_reg)
            );

            // Read-before-write single-port RAM, word address = byte address[7:2].
            always @(posedge clk) begin
                if (mem_init) begin
                    for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
                end else if (ram_req_o[gi]) begin
                    rd_reg <= mem[ram_addr_o[gi][7:2]];
                    if (ram_we_o[gi]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (ram_be_o[gi][b]) mem[ram_addr_o[gi][7:2]][8*b +: 8] <= ram_wd_o[gi][8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus for dut k; eg: 0 no grant, 1 instr grant, 2 data grant; er = expected rdata.
    task automatic step(input int k, input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [3:0] be, input logic [31:0] da,
                        input logic [31:0] wd, input int eg, input logic [31:0] er);
        @(posedge clk);
        #1;
        rst_n = rst;
        if (!rst) begin
            for (int j = 0; j < 4; j++) exp_q[j].delete();
        end
        for (int j = 0; j < 2; j++) begin
            i_req_s[j] = 1'b0; i_addr_s[j] = 32'h0; d_req_s[j] = 1'b0; d_addr_s[j] = 32'h0;
            d_we_s[j] = 1'b0; d_be_s[j] = 4'h0; d_wdata_s[j] = 32'h0;
            exp_gnt[2*j] = 1'b0; exp_gnt[2*j+1] = 1'b0;
            exp_rreq[j] = 1'b0; exp_rwe[j] = 1'b0; exp_rbe[j] = 4'h0; exp_raddr[j] = 32'h0; exp_rwd[j] = 32'h0;
        end
        i_req_s[k] = ir; i_addr_s[k] = ia; d_req_s[k] = dr; d_we_s[k] = dw;
        d_be_s[k] = be; d_addr_s[k] = da; d_wdata_s[k] = wd;
        if (eg == 1) begin
            exp_gnt[2*k] = 1'b1; exp_rreq[k] = 1'b1; exp_rbe[k] = 4'hF; exp_raddr[k] = ia;
            exp_q[2*k].push_back(exp_t'{stamp: cyc, data: er});
        end else if (eg == 2) begin
            exp_gnt[2*k+1] = 1'b1; exp_rreq[k] = 1'b1; exp_rwe[k] = dw; exp_rbe[k] = be;
            exp_raddr[k] = da; exp_rwd[k] = wd;
            exp_q[2*k+1].push_back(exp_t'{stamp: cyc, data: er});
        end
        run = 1'b1;
    endtask

    task automatic idle(input int k);
        step(k, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    // Monitor: combinational grant/RAM bus checks plus scoreboard pops on responses.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] erd;
        int          q;
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                check("i_gnt", k, 64'(gnt_o[2*k]), 64'(exp_gnt[2*k]));
                check("d_gnt", k, 64'(gnt_o[2*k+1]), 64'(exp_gnt[2*k+1]));
                check("ram_ctl", k, 64'({ram_req_o[k], ram_we_o[k], ram_be_o[k]}),
                      64'({exp_rreq[k], exp_rwe[k], exp_rbe[k]}));
                check("ram_addr", k, 64'(ram_addr_o[k]), 64'(exp_raddr[k]));
                check("ram_wdata", k, 64'(ram_wd_o[k]), 64'(exp_rwd[k]));
                for (int p = 0; p < 2; p++) begin
                    q = 2*k + p;
                    ev = 1'b0;
                    erd = 32'h0;
                    if (exp_q[q].size() > 0 && exp_q[q][0].stamp == cyc - 1) begin
                        ev = 1'b1;
                        erd = exp_q[q][0].data;
                        void'(exp_q[q].pop_front());
                    end
                    check(p ? "d_rvalid" : "i_rvalid", k, 64'(rvalid_o[q]), 64'(ev));
                    check(p ? "d_rdata" : "i_rdata", k, 64'(rdata_o[q]), 64'(erd));
                end
            end
            if (done) begin
                for (int j = 0; j < 4; j++) check("drain", j / 2, 64'(exp_q[j].size()), 64'd0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; vectors = 0; errors = 0;
        run = 1'b0; done = 1'b0; mem_init = 1'b1;
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            i_req_s[j] = 1'b0; i_addr_s[j] = 32'h0; d_req_s[j] = 1'b0; d_addr_s[j] = 32'h0;
            d_we_s[j] = 1'b0; d_be_s[j] = 4'h0; d_wdata_s[j] = 32'h0;
        end

        // Reset held with requests present: no grants, quiet RAM bus.
        step(0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h14, 32'hDEAD_BEEF, 0, 32'h0);
        step(1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 0, 32'h0);
        mem_init = 1'b0;

        // Instr only, repeated address 0x10 -> word 4.
        for (int n = 0; n < 3; n++)
            step(0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A5_0004);

        // Round robin contention: D,I,D,I,D,I.
        for (int n = 0; n < 6; n++)
            step(0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0,
                 (n % 2 == 0) ? 2 : 1, (n % 2 == 0) ? 32'hA5A5_0005 : 32'hA5A5_0004);

        // Full write, partial write, read back at 0x20.
        step(0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h1122_3344, 2, 32'hA5A5_0008);
        step(0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD, 2, 32'h1122_3344);
        step(0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 2, 32'h1122_CCDD);
        idle(0);

        // Fixed priority, MAX_WAIT=4: four data grants then one instr grant, twice.
        step(1, 1'b1, 1'b1, 32'h1C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A5_0007);
        for (int n = 0; n < 10; n++)
            step(1, 1'b1, 1'b1, 32'h1C, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0,
                 (n % 5 == 4) ? 1 : 2, (n % 5 == 4) ? 32'hA5A5_0007 : 32'hA5A5_0006);
        idle(1);

        // Reset right after a data grant: response dropped, data wins first afterwards.
        step(0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 2, 32'hA5A5_0005);
        step(0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 0, 32'h0);
        step(0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 2, 32'hA5A5_0005);
        step(0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1, 32'hA5A5_0004);
        idle(0);
        idle(0);

        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = round-robin arbitration, 0 = fixed priority with data port preferred.
REQ-002 Parameter MAX_WAIT, default 4: cycles the instr port may be denied under fixed priority before it is forced a grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  instr-port read request.
REQ-006 i_addr  input  32  instr-port byte address.
REQ-007 i_gnt  output  1  instr request accepted this cycle.
REQ-008 i_rvalid  output  1  instr read data valid.
REQ-009 i_rdata  output  32  instr read data.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_we  input  1  data-port write enable.
REQ-013 d_be  input  4  data-port byte enables.
REQ-014 d_wdata  input  32  data-port write data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data response valid, for reads and writes.
REQ-017 d_rdata  output  32  data read data.
REQ-018 ram_req, ram_addr[31:0], ram_we, ram_be[3:0], ram_wdata[31:0]  output  to single-port RAM.
REQ-019 ram_rdata  input  32  RAM read data, valid one cycle after ram_req.

Function
REQ-020 Grant is combinational: at most one of i_gnt/d_gnt high per cycle; x_gnt high only when x_req high.
REQ-021 Only one requester active -> it is granted the same cycle.
REQ-022 Both requesting, ROUND_ROBIN=1 -> grant the port not granted most recently; after reset, data wins first.
REQ-023 Both requesting, ROUND_ROBIN=0 -> data wins, unless wait counter = MAX_WAIT, then instr wins.
REQ-024 Wait counter (4 bit): increments each cycle i_req high and i_gnt low; clears on i_gnt or i_req low; saturates at MAX_WAIT; unused (held 0) when ROUND_ROBIN=1.
REQ-025 RAM outputs driven combinationally from the granted port; instr grant drives ram_we=0, ram_be=4'hF, ram_wdata=0; no grant drives ram_req=0 and all other RAM outputs 0.
REQ-026 Owner register (OWN_NONE/OWN_INSTR/OWN_DATA) records the port granted this cycle; next cycle selects response routing.
REQ-027 Response latency exactly 1 cycle: x_rvalid high in the cycle after x_gnt, for one cycle per grant.
REQ-028 x_rdata = ram_rdata when x_rvalid, else 32'h0; data-write response returns pre-write word.
REQ-029 Back-to-back grants every cycle supported, any port mix, no bubble.
REQ-030 Requester holds req/addr/we/be/wdata stable until gnt; changes before gnt are legal and take effect on the next arbitration.
REQ-031 Last-winner register updates only on a cycle with a grant.

Reset
REQ-032 rst_n low asynchronously: owner=OWN_NONE, last-winner=instr, wait counter=0; i_rvalid=d_rvalid=0, i_rdata=d_rdata=0.
REQ-033 Grants and RAM outputs while rst_n low = 0 regardless of requests.
REQ-034 Reset mid-operation discards any pending response; no rvalid in the first cycle after reset release.

Structure
REQ-035 Package ram_arbiter_pkg holds the owner enum typedef and the wait-counter width constant.
REQ-036 Single module, no sub-modules; instantiated between core buses and ram.

Verification
REQ-037 Instr only, i_addr=32'h10 repeatedly -> i_gnt every cycle, i_rvalid one cycle later with ram word 4.
REQ-038 ROUND_ROBIN=1, both requesting for 6 cycles -> grants D,I,D,I,D,I; responses routed to the matching port.
REQ-039 ROUND_ROBIN=0, MAX_WAIT=4, both requesting continuously -> 4 data grants, 1 instr grant, repeating.
REQ-040 Data write d_addr=32'h20, d_be=4'b0011, d_wdata=32'hAABBCCDD over 32'h11223344, then read -> d_rvalid both; write returns 32'h11223344, read returns 32'h1122CCDD.
REQ-041 rst_n pulsed low the cycle after a data grant -> d_rvalid stays 0, RAM outputs 0 during reset, first post-reset contention granted to data.
REQ-042 Assertions across all tests: never both gnt high; rvalid only one cycle after matching gnt; rdata zero when rvalid low.
